// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential bitmap encoder.
//   N_DEF  : default index width
//   VEC_W  : request vector width (2^N_DEF)
//   state_e: controller state, IDLE = 0, BUSY = 1
package encoder_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned VEC_W = 2 ** N_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/lowest_set16.sv
// Combinational lowest-set-bit finder.
//   vec   in  2^N  vector to scan
//   index out N    position of lowest set bit (0 when vec is zero)
//   found out 1    vec has at least one bit set
//   rest  out 2^N  vec with its lowest set bit cleared
module lowest_set16
    import encoder_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [2**N-1:0] vec,
    output logic [N-1:0]    index,
    output logic            found,
    output logic [2**N-1:0] rest
);

    localparam int unsigned W = 2 ** N;
    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        index = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = i[N-1:0];
            end
        end
        found = |vec;
        rest  = vec & (vec - ONE);
    end

endmodule

// File: rtl/encoder4_stream.sv
// Sequential 2^N-to-N bitmap encoder. Accepts a request bitmap over a
// valid/ready handshake and streams the index of every set bit, lowest
// first, one per output handshake, flagging the final index of each vector.
//   CLK       in  1    rising-edge clock
//   RESET     in  1    synchronous active-high reset
//   in_valid  in  1    upstream offers in_data
//   in_ready  out 1    block accepts in_data this cycle
//   in_data   in  2^N  request bitmap
//   out_valid out 1    out_index/out_last valid
//   out_ready in  1    downstream consumes current index
//   out_index out N    lowest pending index
//   out_last  out 1    current index is the last of its vector
module encoder4_stream
    import encoder_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_index,
    output logic            out_last
);

    localparam int unsigned W = 2 ** N;

    state_e         state_q, state_d;
    logic [W-1:0]   pending_q, pending_d;
    logic [W-1:0]   rest;
    logic           found;

    lowest_set16 #(
        .N (N)
    ) u_lowest (
        .vec   (pending_q),
        .index (out_index),
        .found (found),
        .rest  (rest)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        out_valid = (state_q == BUSY);
        out_last  = out_valid && found && (rest == '0);
        // Ready while idle, or when the final index leaves this cycle.
        in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);

        if (out_valid && out_ready) begin
            pending_d = rest;
            if (out_last) begin
                state_d = IDLE;
            end
        end

        // Zero vectors are consumed and dropped.
        if (in_valid && in_ready && (in_data != '0)) begin
            pending_d = in_data;
            state_d   = BUSY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_encoder4_stream.sv
module tb_encoder4_stream;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    encoder4_stream dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last)
    );

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
        next_cycle();
        next_cycle();
        RESET = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        #1;
        checks++;
        if ({in_ready, out_valid, out_index, out_last} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b idx=%0d last=%b, expected rdy=1 v=0 idx=0 last=0",
                     in_ready, out_valid, out_index, out_last);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 16'h0001; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got in_ready=%b, expected 1", in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_out: got v=%b idx=%0d last=%b, expected v=1 idx=0 last=1",
                     out_valid, out_index, out_last);
        end
        next_cycle();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_done: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_multi();
        int unsigned exp_idx [4];
        exp_idx = '{0, 5, 10, 15};
        in_valid = 1'b1; in_data = 16'h8421; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({out_valid, out_index, out_last} !== {1'b1, exp_idx[i][3:0], (i == 3)}) begin
                errors++;
                $display("FAIL multi_order[%0d]: got v=%b idx=%0d last=%b, expected v=1 idx=%0d last=%b",
                         i, out_valid, out_index, out_last, exp_idx[i], (i == 3));
            end
            next_cycle();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_end: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_all_ones();
        in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({out_valid, out_index, out_last} !== {1'b1, 4'(i), (i == 15)}) begin
                errors++;
                $display("FAIL all_ones[%0d]: got v=%b idx=%0d last=%b, expected v=1 idx=%0d last=%b",
                         i, out_valid, out_index, out_last, i, (i == 15));
            end
            next_cycle();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_ones_end: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 16'h0006; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b0; in_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b idx=%0d last=%b rdy=%b, expected v=1 idx=1 last=0 rdy=0",
                         i, out_valid, out_index, out_last, in_ready);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL release_first: got v=%b idx=%0d last=%b, expected v=1 idx=1 last=0",
                     out_valid, out_index, out_last);
        end
        next_cycle();
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL release_second: got v=%b idx=%0d last=%b, expected v=1 idx=2 last=1",
                     out_valid, out_index, out_last);
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_end: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 16'h0003; out_ready = 1'b1;
        next_cycle();
        in_data = 16'h0010;
        #1;
        checks++;
        if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_0: got v=%b idx=%0d last=%b rdy=%b, expected v=1 idx=0 last=0 rdy=0",
                     out_valid, out_index, out_last, in_ready);
        end
        next_cycle();
        checks++;
        if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_1: got v=%b idx=%0d last=%b rdy=%b, expected v=1 idx=1 last=1 rdy=1",
                     out_valid, out_index, out_last, in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL b2b_4: got v=%b idx=%0d last=%b, expected v=1 idx=4 last=1",
                     out_valid, out_index, out_last);
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_zero_vector();
        in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
        next_cycle();
        in_data = 16'h0100;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_drop: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL zero_next: got v=%b idx=%0d last=%b, expected v=1 idx=8 last=1",
                     out_valid, out_index, out_last);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_index} !== {1'b1, 4'(i)}) begin
                errors++;
                $display("FAIL mid_pre[%0d]: got v=%b idx=%0d, expected v=1 idx=%0d",
                         i, out_valid, out_index, i);
            end
            next_cycle();
        end
        RESET = 1'b1;
        next_cycle();
        RESET = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got v=%b idx=%0d last=%b rdy=%b, expected v=0 idx=0 last=0 rdy=1",
                     out_valid, out_index, out_last, in_ready);
        end
        in_valid = 1'b1; in_data = 16'h0004;
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL mid_new: got v=%b idx=%0d last=%b, expected v=1 idx=2 last=1",
                     out_valid, out_index, out_last);
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_end: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    // Transaction model: a queue of indices still owed to downstream.
    task automatic test_random();
        int unsigned q[$];
        bit          exp_v;
        bit          exp_rdy;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = 16'h0000;
                1:       in_data = 16'(1 << $urandom_range(0, 15));
                default: in_data = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v   = (q.size() != 0);
            exp_rdy = !exp_v || (out_ready && q.size() == 1);
            checks++;
            if ({out_valid, in_ready} !== {exp_v, exp_rdy}) begin
                errors++;
                $display("FAIL rand_hs[%0d]: got v=%b rdy=%b, expected v=%b rdy=%b",
                         c, out_valid, in_ready, exp_v, exp_rdy);
            end
            if (exp_v) begin
                checks++;
                if ({out_index, out_last} !== {4'(q[0]), (q.size() == 1)}) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got idx=%0d last=%b, expected idx=%0d last=%b",
                             c, out_index, out_last, q[0], (q.size() == 1));
                end
            end
            if (exp_v && out_ready) begin
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                for (int b = 0; b < 16; b++) begin
                    if (in_data[b]) q.push_back(b);
                end
            end
            next_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        RESET = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_multi();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_zero_vector();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
